// File: rtl/mult_share_ctrl_pkg.sv
// mult_share_ctrl_pkg: shared widths and FSM encoding for the shared-multiplier controller.
package mult_share_ctrl_pkg;
    localparam int MUL_W  = 16;
    localparam int PROD_W = 32;
    localparam int ID_W   = 3;
    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
endpackage

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or after ptr.
module rr_arbiter
    import mult_share_ctrl_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] idx,
    output logic            valid
);
    int best;
    always_comb begin
        best  = NREQ;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (req[k] && ((k + NREQ - int'(ptr)) % NREQ) < best) begin
                best = (k + NREQ - int'(ptr)) % NREQ;
                idx  = ID_W'(k);
            end
        end
        valid = |req;
        grant = valid ? (NREQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: shares one 16x16 multiplier among NREQ requesters with round-robin grant,
// settle/timeout handling and a valid/ready response bus.
module mult_share_ctrl
    import mult_share_ctrl_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*MUL_W-1:0]  op_a,
    input  logic [NREQ*MUL_W-1:0]  op_b,
    output logic [NREQ-1:0]        ack,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [PROD_W-1:0]      resp_data,
    output logic                   resp_err,
    output logic                   mul_en,
    output logic [MUL_W-1:0]       mul_a,
    output logic [MUL_W-1:0]       mul_b,
    input  logic                   mul_rdy,
    input  logic [PROD_W-1:0]      mul_p
);
    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [7:0]      cnt;
    logic [7:0]      timer;
    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] idx;
    logic            valid;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (idx),
        .valid (valid)
    );

    // resp_id doubles as the owner of the in-flight op, so it is latched at grant time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            ack        <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            mul_en     <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            cnt        <= '0;
            timer      <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: if (valid) begin
                    mul_a   <= op_a[int'(idx)*MUL_W +: MUL_W];
                    mul_b   <= op_b[int'(idx)*MUL_W +: MUL_W];
                    ack     <= grant;
                    resp_id <= idx;
                    cnt     <= '0;
                    timer   <= '0;
                    mul_en  <= 1'b1;
                    state   <= RUN;
                end
                RUN: begin
                    cnt   <= mul_rdy ? cnt + 8'd1 : '0;
                    timer <= timer + 8'd1;
                    if (mul_rdy && cnt == 8'(SETTLE - 1)) begin
                        resp_data  <= mul_p;
                        resp_err   <= 1'b0;
                        mul_en     <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (timer == 8'(TIMEOUT - 1)) begin
                        resp_data  <= '0;
                        resp_err   <= 1'b1;
                        mul_en     <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    rr_ptr     <= (int'(resp_id) == NREQ - 1) ? '0 : resp_id + 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb_mult_share_ctrl: randomized transaction-level check of mult_share_ctrl against a
// round-robin / settle / timeout reference model.
module tb_mult_share_ctrl;
    import mult_share_ctrl_pkg::*;
    localparam int NREQ = 4, SETTLE = 2, TIMEOUT = 15;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*16-1:0]   op_a = '0;
    logic [NREQ*16-1:0]   op_b = '0;
    logic [NREQ-1:0]      ack;
    logic                 resp_valid;
    logic                 resp_ready = 1'b0;
    logic [2:0]           resp_id;
    logic [31:0]          resp_data;
    logic                 resp_err;
    logic                 mul_en;
    logic [15:0]          mul_a;
    logic [15:0]          mul_b;
    logic                 mul_rdy = 1'b0;
    logic [31:0]          mul_p;

    int vectors = 0;
    int miscompares = 0;
    int ptr = 0;

    assign mul_p = 32'(mul_a) * 32'(mul_b);

    mult_share_ctrl #(.NREQ(NREQ), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .op_a       (op_a),
        .op_b       (op_b),
        .ack        (ack),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .mul_en     (mul_en),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_rdy    (mul_rdy),
        .mul_p      (mul_p)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int winner(input logic [NREQ-1:0] r, input int p);
        for (int d = 0; d < NREQ; d++)
            if (((r >> ((p + d) % NREQ)) & NREQ'(1)) != 0) return (p + d) % NREQ;
        return 0;
    endfunction

    // mode: 0 rdy always high, 1 rdy always low, 2 random rdy per cycle
    task automatic op(input logic [NREQ-1:0] r, input bit keep, input int mode, input int hold);
        bit          seq[TIMEOUT];
        int          w, lat, exp_lat, run;
        bit          exp_err, extra_ack, bad;
        logic [15:0] ea, eb;
        logic [31:0] exp_data;
        w  = winner(r, ptr);
        ea = op_a[w*16 +: 16];
        eb = op_b[w*16 +: 16];
        for (int k = 0; k < TIMEOUT; k++)
            seq[k] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
        exp_err = 1'b1;
        exp_lat = TIMEOUT;
        run = 0;
        for (int k = 0; k < TIMEOUT; k++) begin
            run = seq[k] ? run + 1 : 0;
            if (run >= SETTLE) begin
                exp_err = 1'b0;
                exp_lat = k + 1;
                break;
            end
        end
        exp_data = exp_err ? 32'd0 : 32'(ea) * 32'(eb);
        req = r;
        @(negedge clk);
        lat = 0;
        while (ack == '0 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check("ack_onehot", 32'(ack), 32'(1) << w);
        check("mul_a", 32'(mul_a), 32'(ea));
        check("mul_b", 32'(mul_b), 32'(eb));
        check("mul_en_run", 32'(mul_en), 32'd1);
        if (!keep && $urandom_range(0, 1) == 1) req = '0;
        // scramble operands after ack: they must already be latched
        if (!keep) begin
            op_a = {$urandom, $urandom};
            op_b = {$urandom, $urandom};
        end
        lat = 0;
        extra_ack = 1'b0;
        mul_rdy = seq[0];
        while (!resp_valid && lat < TIMEOUT + 4) begin
            @(negedge clk);
            lat++;
            if (ack != '0) extra_ack = 1'b1;
            if (lat < TIMEOUT) mul_rdy = seq[lat];
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("resp_id", 32'(resp_id), 32'(w));
        check("resp_data", resp_data, exp_data);
        check("resp_err", 32'(resp_err), 32'(exp_err));
        check("mul_en_resp", 32'(mul_en), 32'd0);
        check("no_extra_ack", 32'(extra_ack), 32'd0);
        resp_ready = 1'b0;
        bad = 1'b0;
        if (hold > 0) begin
            req = '1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (resp_valid !== 1'b1 || resp_data !== exp_data || resp_id !== 3'(w) ||
                    resp_err !== exp_err || ack != '0 || mul_en !== 1'b0) bad = 1'b1;
            end
            check("hold_stable", 32'(bad), 32'd0);
        end
        resp_ready = 1'b1;
        req = keep ? r : '0;
        @(negedge clk);
        check("hs_valid_low", 32'(resp_valid), 32'd0);
        check("mul_a_hold", 32'(mul_a), 32'(ea));
        resp_ready = 1'b0;
        ptr = (w + 1) % NREQ;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_id", 32'(resp_id), 32'd0);
        check("rst_data", resp_data, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_mul", {mul_a, mul_b}, 32'd0);
        check("rst_en", 32'(mul_en), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NREQ; i++) begin
            op_a[i*16 +: 16] = 16'(i + 7);
            op_b[i*16 +: 16] = 16'(3 * i + 1);
        end
        for (int i = 0; i < 5; i++) op(4'b1111, 1'b1, 0, 0);
        req = '0;

        op_a[31:16] = 16'd3;
        op_b[31:16] = 16'd5;
        op(4'b0010, 1'b0, 0, 0);

        op_a = '1;
        op_b = '1;
        op(4'b0100, 1'b0, 0, 0);
        op_a = '0;
        op_b = '1;
        op(4'b1000, 1'b0, 0, 0);

        op_a = {$urandom, $urandom};
        op_b = {$urandom, $urandom};
        op(4'b0101, 1'b0, 0, 10);

        op(4'b0001, 1'b0, 1, 0);
        op_a = {$urandom, $urandom};
        op_b = {$urandom, $urandom};
        op(4'b0110, 1'b0, 0, 0);

        req = 4'b0100;
        mul_rdy = 1'b0;
        @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);
        check("mid_run_en", 32'(mul_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_en", 32'(mul_en), 32'd0);
        check("arst_mul", {mul_a, mul_b}, 32'd0);
        check("arst_valid_ack", {31'd0, resp_valid | (|ack)}, 32'd0);
        check("arst_data", resp_data, 32'd0);
        check("arst_id_err", {28'd0, resp_id, resp_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ptr = 0;
        op_a = {$urandom, $urandom};
        op_b = {$urandom, $urandom};
        op(4'b1111, 1'b0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            logic [NREQ-1:0] r;
            r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            op_a = {$urandom, $urandom};
            op_b = {$urandom, $urandom};
            op(r, 1'b0, $urandom_range(0, 9) < 2 ? 1 : 2, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
